// File: rtl/router_pkg.sv
// router_pkg: shared defaults for the router output-side synchronizer.
//   ROUTER_NUM_CH  - default number of output channels/FIFOs
//   ROUTER_ADDR_W  - default width of the header address field
//   ROUTER_TIMEOUT - default unread-valid cycles before a soft reset
package router_pkg;

  localparam int unsigned ROUTER_NUM_CH  = 3;
  localparam int unsigned ROUTER_ADDR_W  = 2;
  localparam int unsigned ROUTER_TIMEOUT = 30;

endpackage

// File: rtl/router_sync_timer.sv
// router_sync_timer: one channel's idle timeout.
//   clocks     - clock, rising edge
//   resetns    - asynchronous active-low reset
//   idle       - channel holds valid data that is not being read this cycle
//   soft_reset - registered one-cycle pulse after TIMEOUT consecutive idle edges
module router_sync_timer #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clocks,
  input  logic resetns,
  input  logic idle,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt;

  // Wrapping to zero on the pulse makes a permanently idle channel
  // pulse again every TIMEOUT cycles.
  always_ff @(posedge clocks or negedge resetns) begin
    if (!resetns) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (idle) begin
      if (cnt == CNT_W'(TIMEOUT - 1)) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt        <= cnt + 1'b1;
        soft_reset <= 1'b0;
      end
    end else begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// router_sync_n: synchronizer between the router FSM and NUM_CH output FIFOs.
//   clocks        - clock, rising edge
//   resetns       - asynchronous active-low reset
//   detect_adds   - header strobe; latches data_ins as the destination address
//   data_ins      - address bits of the header byte
//   write_enb_reg - FSM write request, steered to the addressed FIFO
//   read_enb      - per-channel read enable from the receiver
//   empty / full  - per-FIFO status flags
//   valid_out     - per-channel data valid (~empty, combinational)
//   write_enb     - one-hot FIFO write enable (zero until a legal address is latched)
//   fifo_full     - full flag of the addressed FIFO (zero for an illegal address)
//   soft_reset    - per-channel one-cycle timeout pulse
//   addr_err      - one-cycle pulse after a header addressing a nonexistent channel
module router_sync_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH  = ROUTER_NUM_CH,
  parameter int unsigned ADDR_W  = ROUTER_ADDR_W,
  parameter int unsigned TIMEOUT = ROUTER_TIMEOUT,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic              clocks,
  input  logic              resetns,
  input  logic              detect_adds,
  input  logic [ADDR_W-1:0] data_ins,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] valid_out,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              in_range;

  // One extra bit so NUM_CH == 2**ADDR_W compares correctly.
  assign in_range = ({1'b0, data_ins} < (ADDR_W + 1)'(NUM_CH));

  always_ff @(posedge clocks or negedge resetns) begin
    if (!resetns) begin
      addr     <= '0;
      addr_ok  <= 1'b0;
      addr_err <= 1'b0;
    end else if (detect_adds) begin
      addr     <= data_ins;
      addr_ok  <= in_range;
      addr_err <= ~in_range;
    end else begin
      addr_err <= 1'b0;
    end
  end

  // Decoded by compare rather than indexed so an out-of-range addr can
  // never select a nonexistent bit.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr_ok && (addr == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign valid_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clocks     (clocks),
      .resetns    (resetns),
      .idle       (valid_out[g] & ~read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: two instances (defaults 3ch/T=30, and 4ch/T=5) driven by
// directed phases and random traffic, checked each cycle against a model that
// tracks the latched header and each channel's idle run length.
module tb_router_sync_n;

  logic       clocks = 1'b0;
  logic       resetns;
  logic       detect_adds;
  logic [1:0] data_ins;
  logic       write_enb_reg;
  logic [3:0] rd  [2];
  logic [3:0] emp [2];
  logic [3:0] fl  [2];

  logic [2:0] vo_a, we_a, sr_a;
  logic       ff_a, ae_a;
  logic [3:0] vo_b, we_b, sr_b;
  logic       ff_b, ae_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference state, index 0 = instance A, 1 = instance B
  int m_addr [2];
  bit m_ok   [2];
  bit m_err  [2];
  int run    [2][4];
  bit m_sr   [2][4];

  always #5 clocks = ~clocks;

  router_sync_n u_dut_a (
    .clocks        (clocks),
    .resetns       (resetns),
    .detect_adds   (detect_adds),
    .data_ins      (data_ins),
    .write_enb_reg (write_enb_reg),
    .read_enb      (rd[0][2:0]),
    .empty         (emp[0][2:0]),
    .full          (fl[0][2:0]),
    .valid_out     (vo_a),
    .write_enb     (we_a),
    .fifo_full     (ff_a),
    .soft_reset    (sr_a),
    .addr_err      (ae_a)
  );

  router_sync_n #(
    .NUM_CH  (4),
    .ADDR_W  (2),
    .TIMEOUT (5)
  ) u_dut_b (
    .clocks        (clocks),
    .resetns       (resetns),
    .detect_adds   (detect_adds),
    .data_ins      (data_ins),
    .write_enb_reg (write_enb_reg),
    .read_enb      (rd[1]),
    .empty         (emp[1]),
    .full          (fl[1]),
    .valid_out     (vo_b),
    .write_enb     (we_b),
    .fifo_full     (ff_b),
    .soft_reset    (sr_b),
    .addr_err      (ae_b)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = 0;
      m_ok[k]   = 1'b0;
      m_err[k]  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        run[k][i]  = 0;
        m_sr[k][i] = 1'b0;
      end
    end
  endfunction

  // Advance the model by one rising edge using the currently applied inputs.
  function automatic void model_step();
    int nch, tmo;
    if (!resetns) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      nch = (k == 0) ? 3 : 4;
      tmo = (k == 0) ? 30 : 5;
      if (detect_adds) begin
        m_addr[k] = int'(data_ins);
        m_ok[k]   = (int'(data_ins) < nch);
        m_err[k]  = !(int'(data_ins) < nch);
      end else begin
        m_err[k] = 1'b0;
      end
      for (int i = 0; i < nch; i++) begin
        if (!emp[k][i] && !rd[k][i]) begin
          run[k][i]++;
          m_sr[k][i] = ((run[k][i] % tmo) == 0);
        end else begin
          run[k][i]  = 0;
          m_sr[k][i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic check_all();
    logic [3:0] e_vo, e_we, e_sr;
    logic       e_ff;
    for (int k = 0; k < 2; k++) begin
      e_vo = ~emp[k];
      e_we = '0;
      e_ff = 1'b0;
      e_sr = '0;
      if (m_ok[k]) begin
        e_we[m_addr[k]] = write_enb_reg;
        e_ff = fl[k][m_addr[k]];
      end
      for (int i = 0; i < 4; i++) e_sr[i] = m_sr[k][i];
      if (k == 0) begin
        e_vo[3] = 1'b0;
        chk("a_valid_out",  {1'b0, vo_a}, e_vo);
        chk("a_write_enb",  {1'b0, we_a}, e_we);
        chk("a_fifo_full",  {3'b000, ff_a}, {3'b000, e_ff});
        chk("a_soft_reset", {1'b0, sr_a}, e_sr);
        chk("a_addr_err",   {3'b000, ae_a}, {3'b000, m_err[0]});
      end else begin
        chk("b_valid_out",  vo_b, e_vo);
        chk("b_write_enb",  we_b, e_we);
        chk("b_fifo_full",  {3'b000, ff_b}, {3'b000, e_ff});
        chk("b_soft_reset", sr_b, e_sr);
        chk("b_addr_err",   {3'b000, ae_b}, {3'b000, m_err[1]});
      end
    end
  endtask

  // Called at edge+1 after inputs are driven; returns at the next edge+1.
  task automatic tick();
    #3;
    check_all();
    model_step();
    @(posedge clocks);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #1;
    resetns = 1'b0;
    model_clear();
    #1;
    check_all();
    tick();
    resetns = 1'b1;
  endtask

  task automatic idle_inputs();
    detect_adds   = 1'b0;
    data_ins      = 2'd0;
    write_enb_reg = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd[k]  = '0;
      emp[k] = '1;
      fl[k]  = '0;
    end
  endtask

  initial begin
    resetns = 1'b0;
    idle_inputs();
    model_clear();
    #1;
    ticks(2);
    resetns = 1'b1;
    ticks(1);

    // Header to channel 1; old (empty) address still steers in the detect cycle
    detect_adds = 1'b1; data_ins = 2'd1; write_enb_reg = 1'b1; fl[0] = 4'b0010; fl[1] = 4'b0010;
    tick();
    detect_adds = 1'b0;
    ticks(2);
    fl[0] = 4'b0101; fl[1] = 4'b0101;
    ticks(2);

    // Channel 0 of A / channel 3 of B held valid and unread
    write_enb_reg = 1'b0;
    emp[0] = 4'b1110; emp[1] = 4'b0111;
    ticks(65);

    // Channel 2 of A read once late in the count
    emp[0] = 4'b1011; emp[1] = 4'b1111;
    ticks(28);
    rd[0] = 4'b0100; rd[1] = 4'b0100;
    tick();
    rd[0] = '0; rd[1] = '0;
    ticks(32);

    // Out-of-range header for A, channel 3 for B, with every FIFO full
    detect_adds = 1'b1; data_ins = 2'd3; write_enb_reg = 1'b1; fl[0] = '1; fl[1] = '1;
    tick();
    detect_adds = 1'b0;
    ticks(3);

    // Async reset partway into a count, then a full timeout again
    write_enb_reg = 1'b0;
    emp[0] = 4'b1110; emp[1] = 4'b1110;
    ticks(20);
    async_reset();
    write_enb_reg = 1'b1;
    ticks(35);

    // Random traffic with sticky empty flags so long idle runs occur
    for (int n = 0; n < 1500; n++) begin
      detect_adds   = ($urandom_range(15) == 0);
      data_ins      = 2'($urandom_range(3));
      write_enb_reg = 1'($urandom_range(1));
      for (int k = 0; k < 2; k++) begin
        fl[k] = 4'($urandom_range(15));
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(59) == 0) emp[k][i] = ~emp[k][i];
          rd[k][i] = ($urandom_range(39) == 0);
        end
      end
      if ((n % 317) == 200) async_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
